eth_miim_cmdq: RTL and testbench

Command queue and sequencer that sits directly upstream of the MII management engine (eth_miim) and drives its command inputs. It buffers PHY register write/read requests from a host or boot-time init block and issues them one at a time using the engine's WCtrlData/RStat level-command handshake. It returns one response per command with read data or a timeout flag, and arbitrates scan-status polling against queued commands.

---
 rtl/eth_miim_cmdq.sv | 165 ++++++++++++++++
 tb/tb_eth_miim_cmdq.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_miim_cmdq.sv
// Command queue and sequencer in front of the MII management engine.
// Buffers PHY register read/write requests, issues them one at a time over the
// engine's level-command handshake, returns one response per command and
// arbitrates scan-status polling against queued work.
module eth_miim_cmdq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TO_W  = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [4:0]                 cmd_fiad,
    input  logic [4:0]                 cmd_rgad,
    input  logic [15:0]                cmd_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic                       rsp_write,
    output logic [15:0]                rsp_rdata,
    output logic                       rsp_timeout,
    input  logic                       scan_en,
    input  logic [4:0]                 scan_fiad,
    input  logic [4:0]                 scan_rgad,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       idle,
    output logic                       WCtrlData,
    output logic                       RStat,
    output logic                       ScanStat,
    output logic [4:0]                 Fiad,
    output logic [4:0]                 Rgad,
    output logic [15:0]                CtrlData,
    input  logic                       Busy,
    input  logic [15:0]                Prsd,
    input  logic                       WCtrlDataStart,
    input  logic                       RStatStart,
    input  logic                       UpdateMIIRX_DATAReg
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = 27;  // {write, fiad, rgad, wdata}
    // Timeout fires on the cycle the counter would become all-ones.
    localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {StIdle, StDrain, StIssue, StWait, StResp} state_t;

    state_t          state_q;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   count_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [4:0]      fiad_q;
    logic [4:0]      rgad_q;
    logic            op_q;
    // Engine may still be mid-frame (scan in progress or timed-out command).
    logic            drain_q;

    logic empty, push, pop, start_seen, done, to_hit;

    assign empty      = (count_q == '0);
    assign cmd_ready  = (count_q != LW'(DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state_q == StIdle) & ~empty & ~rsp_valid & ~drain_q;
    assign level      = count_q;
    assign idle       = empty & (state_q == StIdle) & ~rsp_valid;
    assign ScanStat   = scan_en & (state_q == StIdle) & empty & ~rsp_valid;
    assign Fiad       = ScanStat ? scan_fiad : fiad_q;
    assign Rgad       = ScanStat ? scan_rgad : rgad_q;
    assign start_seen = op_q ? WCtrlDataStart : RStatStart;
    assign done       = op_q ? ~Busy : UpdateMIIRX_DATAReg;
    assign to_hit     = (to_cnt_q == TO_LAST);

    // FIFO storage, no reset needed.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {cmd_write, cmd_fiad, cmd_rgad, cmd_wdata};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + LW'(push) - LW'(pop);
        end
    end

    // Sequencer FSM with registered engine commands and responses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= StIdle;
            WCtrlData   <= 1'b0;
            RStat       <= 1'b0;
            fiad_q      <= '0;
            rgad_q      <= '0;
            CtrlData    <= '0;
            op_q        <= 1'b0;
            drain_q     <= 1'b0;
            to_cnt_q    <= '0;
            rsp_valid   <= 1'b0;
            rsp_write   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (ScanStat) drain_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (pop) begin
                        {op_q, fiad_q, rgad_q, CtrlData} <= mem[rd_ptr_q];
                        WCtrlData <= mem[rd_ptr_q][EW-1];
                        RStat     <= ~mem[rd_ptr_q][EW-1];
                        to_cnt_q  <= '0;
                        state_q   <= StIssue;
                    end else if (~empty && ~rsp_valid) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!Busy) begin
                        drain_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StIssue, StWait: begin
                    to_cnt_q <= to_cnt_q + TO_W'(1);
                    if (state_q == StIssue && start_seen) begin
                        WCtrlData <= 1'b0;
                        RStat     <= 1'b0;
                        state_q   <= StWait;
                    end else if (state_q == StWait && done) begin
                        rsp_valid   <= 1'b1;
                        rsp_write   <= op_q;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= op_q ? 16'h0000 : Prsd;
                        state_q     <= StResp;
                    end else if (to_hit) begin
                        WCtrlData   <= 1'b0;
                        RStat       <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_write   <= op_q;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        drain_q     <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_miim_cmdq.sv
// Directed bench for eth_miim_cmdq with a small behavioural engine model.
module tb_eth_miim_cmdq;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_fiad, cmd_rgad;
    logic [15:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic        scan_en;
    logic [4:0]  scan_fiad, scan_rgad;
    logic [2:0]  level;
    logic        idle, WCtrlData, RStat, ScanStat;
    logic [4:0]  Fiad, Rgad;
    logic [15:0] CtrlData;
    logic        Busy, WCtrlDataStart, RStatStart, UpdateMIIRX_DATAReg;
    logic [15:0] Prsd;

    int total = 0;
    int bad = 0;

    // Engine model knobs
    logic        no_start = 1'b0;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_val = 16'h0;
    logic [2:0]  eng_cnt;
    logic        eng_rd;

    eth_miim_cmdq #(.DEPTH(4), .TO_W(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_fiad(cmd_fiad), .cmd_rgad(cmd_rgad), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .scan_en(scan_en), .scan_fiad(scan_fiad), .scan_rgad(scan_rgad),
        .level(level), .idle(idle),
        .WCtrlData(WCtrlData), .RStat(RStat), .ScanStat(ScanStat),
        .Fiad(Fiad), .Rgad(Rgad), .CtrlData(CtrlData),
        .Busy(Busy), .Prsd(Prsd), .WCtrlDataStart(WCtrlDataStart),
        .RStatStart(RStatStart), .UpdateMIIRX_DATAReg(UpdateMIIRX_DATAReg)
    );

    always #5 Clk = ~Clk;

    // Engine: accepts a command with a one-cycle start pulse, stays busy 4 cycles,
    // pulses read data at the end. Scanning runs 6-cycle busy frames.
    always @(posedge Clk) begin
        if (Reset) begin
            Busy <= 1'b0; WCtrlDataStart <= 1'b0; RStatStart <= 1'b0;
            UpdateMIIRX_DATAReg <= 1'b0; Prsd <= 16'h0; eng_cnt <= 3'd0; eng_rd <= 1'b0;
        end else begin
            WCtrlDataStart <= 1'b0; RStatStart <= 1'b0; UpdateMIIRX_DATAReg <= 1'b0;
            if (eng_cnt != 3'd0) begin
                eng_cnt <= eng_cnt - 3'd1;
                if (eng_cnt == 3'd1) begin
                    Busy <= 1'b0;
                    if (eng_rd) begin
                        UpdateMIIRX_DATAReg <= 1'b1;
                        Prsd <= use_fixed ? fixed_val : {Fiad, Rgad, 6'h15};
                    end
                end
            end else if ((WCtrlData || RStat) && !no_start) begin
                WCtrlDataStart <= WCtrlData; RStatStart <= RStat;
                Busy <= 1'b1; eng_cnt <= 3'd4; eng_rd <= RStat;
            end else if (ScanStat) begin
                Busy <= 1'b1; eng_cnt <= 3'd6; eng_rd <= 1'b0;
            end
        end
    end

    // Offer one command and hold it until accepted; returns on a negedge.
    task automatic push(input logic w, input logic [4:0] f, input logic [4:0] r,
                        input logic [15:0] d);
        bit ok;
        ok = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_fiad = f; cmd_rgad = r; cmd_wdata = d;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        total++;
        if (!ok) begin bad++; $display("FAIL push_accept: cmd_ready got 0 want 1"); end
        @(negedge Clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for a response, capture it, and consume it.
    task automatic get_rsp(output bit ok, output logic w, output logic [15:0] d,
                           output logic t);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        w = rsp_write; d = rsp_rdata; t = rsp_timeout;
        if (ok) begin
            rsp_ready = 1'b1;
            @(negedge Clk);
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready); end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL rst_idle: got %b want 1", idle); end
        total++; if (level !== 3'd0) begin bad++; $display("FAIL rst_level: got %0d want 0", level); end
        total++;
        if ({rsp_valid, WCtrlData, RStat, ScanStat} !== 4'b0000) begin
            bad++; $display("FAIL rst_ctrl: got %b want 0000", {rsp_valid, WCtrlData, RStat, ScanStat});
        end
        total++;
        if ({Fiad, Rgad, CtrlData} !== 26'h0) begin
            bad++; $display("FAIL rst_addr: got %h want 0", {Fiad, Rgad, CtrlData});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_single_write();
        bit ok; logic w, t; logic [15:0] d;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_fiad = 5'd1; cmd_rgad = 5'd0; cmd_wdata = 16'h1200;
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++; if (WCtrlData !== 1'b0) begin bad++; $display("FAIL wr_lat1: WCtrlData got %b want 0", WCtrlData); end
        @(negedge Clk);
        total++; if (WCtrlData !== 1'b1) begin bad++; $display("FAIL wr_lat2: WCtrlData got %b want 1", WCtrlData); end
        total++;
        if ({Fiad, Rgad, CtrlData} !== {5'd1, 5'd0, 16'h1200}) begin
            bad++; $display("FAIL wr_fields: got %h want %h", {Fiad, Rgad, CtrlData}, {5'd1, 5'd0, 16'h1200});
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (WCtrlDataStart === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        total++; if (!ok || WCtrlData !== 1'b1) begin bad++; $display("FAIL wr_start: seen %b WCtrlData %b want 1 1", ok, WCtrlData); end
        @(negedge Clk);
        total++; if (WCtrlData !== 1'b0) begin bad++; $display("FAIL wr_drop: WCtrlData got %b want 0", WCtrlData); end
        get_rsp(ok, w, d, t);
        total++;
        if (!ok || {w, d, t} !== {1'b1, 16'h0, 1'b0}) begin
            bad++; $display("FAIL wr_rsp: ok %b got %b/%h/%b want 1/0000/0", ok, w, d, t);
        end
        total++; if (idle !== 1'b1) begin bad++; $display("FAIL wr_idle: got %b want 1", idle); end
    endtask

    task automatic test_read_hold();
        bit ok;
        use_fixed = 1'b1; fixed_val = 16'h796D;
        push(1'b0, 5'd2, 5'd1, 16'hFFFF);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL rd_rsp_valid: got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({rsp_valid, rsp_write, rsp_rdata, rsp_timeout} !== {1'b1, 1'b0, 16'h796D, 1'b0}) begin
                bad++; $display("FAIL rd_hold%0d: got %b/%b/%h/%b want 1/0/796d/0",
                                i, rsp_valid, rsp_write, rsp_rdata, rsp_timeout);
            end
            @(negedge Clk);
        end
        rsp_ready = 1'b1; @(negedge Clk); rsp_ready = 1'b0;
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_consume: rsp_valid got %b want 0", rsp_valid); end
        use_fixed = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok; logic w, t; logic [15:0] d;
        logic       ws [5];
        logic [4:0] f;
        logic [4:0] r;
        ws[0] = 1'b1; ws[1] = 1'b0; ws[2] = 1'b0; ws[3] = 1'b1; ws[4] = 1'b0;
        // First command's response is left pending so the FIFO cannot drain.
        push(1'b1, 5'd7, 5'd7, 16'h5555);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            if (rsp_valid === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        total++; if (!ok) begin bad++; $display("FAIL b2b_first: rsp_valid got 0 want 1"); end
        for (int i = 0; i < 4; i++) push(ws[i], 5'(i + 2), 5'(i + 10), 16'(16'hA000 + i));
        total++; if (level !== 3'd4) begin bad++; $display("FAIL b2b_level: got %0d want 4", level); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: cmd_ready got %b want 0", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = ws[4]; cmd_fiad = 5'd6; cmd_rgad = 5'd14; cmd_wdata = 16'hA004;
        @(negedge Clk);
        total++; if (level !== 3'd4) begin bad++; $display("FAIL b2b_hold: level got %0d want 4", level); end
        get_rsp(ok, w, d, t);
        total++;
        if (!ok || {w, d, t} !== {1'b1, 16'h0, 1'b0}) begin
            bad++; $display("FAIL b2b_rsp0: ok %b got %b/%h/%b want 1/0000/0", ok, w, d, t);
        end
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++; if (!ok) begin bad++; $display("FAIL b2b_fifth: cmd_ready got 0 want 1"); end
        for (int i = 0; i < 5; i++) begin
            f = 5'(i + 2); r = 5'(i + 10);
            get_rsp(ok, w, d, t);
            total++;
            if (!ok || {w, d, t} !== {ws[i], (ws[i] ? 16'h0 : {f, r, 6'h15}), 1'b0}) begin
                bad++; $display("FAIL b2b_rsp%0d: ok %b got %b/%h/%b want %b/%h/0", i + 1, ok, w, d, t,
                                ws[i], (ws[i] ? 16'h0 : {f, r, 6'h15}));
            end
        end
    endtask

    task automatic test_scan();
        bit ok, saw_busy, prev_busy, found; logic w, t; logic [15:0] d;
        scan_fiad = 5'h0A; scan_rgad = 5'h01; scan_en = 1'b1;
        @(negedge Clk);
        total++;
        if ({ScanStat, Fiad, Rgad} !== {1'b1, 5'h0A, 5'h01}) begin
            bad++; $display("FAIL scan_on: got %b/%h/%h want 1/0a/01", ScanStat, Fiad, Rgad);
        end
        // Queue the read just after a scan frame starts so the engine is busy.
        prev_busy = Busy;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Busy === 1'b1 && prev_busy === 1'b0) break;
            prev_busy = Busy;
        end
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_fiad = 5'd3; cmd_rgad = 5'd4; cmd_wdata = 16'h0;
        @(negedge Clk);
        cmd_valid = 1'b0;
        total++; if (ScanStat !== 1'b0) begin bad++; $display("FAIL scan_drop: ScanStat got %b want 0", ScanStat); end
        saw_busy = 0; prev_busy = 1'b1; found = 0;
        for (int i = 0; i < 40; i++) begin
            if (RStat === 1'b1) begin found = 1; break; end
            if (Busy === 1'b1) saw_busy = 1;
            prev_busy = Busy;
            @(negedge Clk);
        end
        total++;
        if ({found, saw_busy, prev_busy} !== 3'b110) begin
            bad++; $display("FAIL scan_drain: found/saw_busy/prev_busy got %b%b%b want 110", found, saw_busy, prev_busy);
        end
        get_rsp(ok, w, d, t);
        total++;
        if (!ok || {w, d, t} !== {1'b0, {5'd3, 5'd4, 6'h15}, 1'b0}) begin
            bad++; $display("FAIL scan_rsp: ok %b got %b/%h/%b want 0/%h/0", ok, w, d, t, {5'd3, 5'd4, 6'h15});
        end
        total++;
        if ({ScanStat, Fiad, Rgad} !== {1'b1, 5'h0A, 5'h01}) begin
            bad++; $display("FAIL scan_resume: got %b/%h/%h want 1/0a/01", ScanStat, Fiad, Rgad);
        end
        scan_en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Busy === 1'b0) break;
            @(negedge Clk);
        end
    endtask

    task automatic test_timeout();
        bit ok; int n; logic w, t; logic [15:0] d;
        no_start = 1'b1;
        push(1'b0, 5'd4, 5'd2, 16'h0);
        push(1'b1, 5'd4, 5'd3, 16'hAAAA);
        ok = 0;
        for (int i = 0; i < 30; i++) begin
            if (RStat === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        n = 0;
        while (RStat === 1'b1 && n < 40) begin n++; @(negedge Clk); end
        total++; if (!ok || n != 15) begin bad++; $display("FAIL to_len: RStat high %0d cycles want 15", n); end
        total++;
        if ({rsp_valid, rsp_write, rsp_rdata, rsp_timeout} !== {1'b1, 1'b0, 16'h0, 1'b1}) begin
            bad++; $display("FAIL to_rsp: got %b/%b/%h/%b want 1/0/0000/1",
                            rsp_valid, rsp_write, rsp_rdata, rsp_timeout);
        end
        no_start = 1'b0;
        get_rsp(ok, w, d, t);
        get_rsp(ok, w, d, t);
        total++;
        if (!ok || {w, d, t} !== {1'b1, 16'h0, 1'b0}) begin
            bad++; $display("FAIL to_next: ok %b got %b/%h/%b want 1/0000/0", ok, w, d, t);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        for (int i = 0; i < 3; i++) push(1'b1, 5'(i + 20), 5'd5, 16'(16'h1000 + i));
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (WCtrlDataStart === 1'b1) begin ok = 1; break; end
            @(negedge Clk);
        end
        @(negedge Clk);
        total++; if (!ok || level !== 3'd2) begin bad++; $display("FAIL mid_level: got %0d want 2", level); end
        Reset = 1'b1;
        @(negedge Clk);
        total++;
        if ({level, rsp_valid, WCtrlData, RStat, ScanStat, idle} !== {3'd0, 5'b00001}) begin
            bad++; $display("FAIL mid_reset: got %b want 00000001",
                            {level, rsp_valid, WCtrlData, RStat, ScanStat, idle});
        end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_fiad = '0; cmd_rgad = '0;
        cmd_wdata = '0; rsp_ready = 1'b0; scan_en = 1'b0; scan_fiad = '0; scan_rgad = '0;
        @(negedge Clk);
        test_reset();
        test_single_write();
        test_read_hold();
        test_back_to_back();
        test_scan();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
